// File: rtl/atomrvcore_pkg.sv
// Shared AtomRV core definitions: fetch FSM states, NOP encoding, base opcodes
// and the default reset vector used by the fetch unit and decode.
package atomrvcore_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_HALT
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/atomrvcore_ifu_if.sv
// Instruction-memory request/grant/response port between the fetch unit (master)
// and the instruction memory (slave).
interface atomrvcore_ifu_if #(
    parameter int DATAWIDTH = 32
);
    logic                 imem_req_o;
    logic [DATAWIDTH-1:0] imem_addr_o;
    logic                 imem_gnt_i;
    logic                 imem_rvalid_i;
    logic [DATAWIDTH-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/atomrvcore_ifu_buf.sv
// Two-entry {PC, instruction} FIFO between instruction memory and decode.
// The head reads as NOP at PC 0 whenever the buffer is empty.
module atomrvcore_ifu_buf
    import atomrvcore_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DATAWIDTH-1:0] push_pc_i,
    input  logic [DATAWIDTH-1:0] push_instr_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output logic [DATAWIDTH-1:0] head_pc_o,
    output logic [DATAWIDTH-1:0] head_instr_o,
    output logic [1:0]           count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [DATAWIDTH-1:0] r_pc    [2];
    logic [DATAWIDTH-1:0] r_instr [2];
    logic                 r_rd_ptr;
    logic                 r_wr_ptr;
    logic [1:0]           r_count;

    // Simultaneous push and pop both take effect and leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push_i) begin
                r_pc[r_wr_ptr]    <= push_pc_i;
                r_instr[r_wr_ptr] <= push_instr_i;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (pop_i) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count_o      = r_count;
    assign empty_o      = (r_count == 2'd0);
    assign full_o       = (r_count == 2'd2);
    assign head_pc_o    = empty_o ? '0 : r_pc[r_rd_ptr];
    assign head_instr_o = empty_o ? DATAWIDTH'(NOP_INSTR) : r_instr[r_rd_ptr];

endmodule

// File: rtl/atomrvcore_ifu.sv
// AtomRV instruction fetch unit: one outstanding fetch, 2-entry buffer, decode redirects.
// Optional misaligned-target trap enabled by defining ATOMRVCORE_IFU_ALIGN_CHECK_EN.
module atomrvcore_ifu
    import atomrvcore_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = DATAWIDTH'(DEFAULT_RESET_PC),
    parameter int                   BUF_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    atomrvcore_ifu_if.master     imem,
    output logic [DATAWIDTH-1:0] instr_o,
    output logic [DATAWIDTH-1:0] PC_o,
    output logic                 instr_valid_o,
    input  logic                 stall_i,
    input  logic                 BE_i,
    input  logic                 UJE_i,
    input  logic                 JALRE_i,
    input  logic [DATAWIDTH-1:0] PC_br_i,
    input  logic [DATAWIDTH-1:0] immed_i,
    input  logic [DATAWIDTH-1:0] jalr_base_i
`ifdef ATOMRVCORE_IFU_ALIGN_CHECK_EN
    ,
    output logic                 fetch_misalign_o
`endif
);

    fetch_state_e         r_state;
    logic [DATAWIDTH-1:0] r_pc;
    logic [DATAWIDTH-1:0] r_req_pc;
    logic                 r_outstanding;
    logic                 r_discard;
    logic                 r_req;

    logic                 w_redirect;
    logic [DATAWIDTH-1:0] w_br_target;
    logic [DATAWIDTH-1:0] w_jalr_sum;
    logic [DATAWIDTH-1:0] w_target_raw;
    logic [DATAWIDTH-1:0] w_target;
    logic                 w_halted;
    logic                 w_gnt_acc;
    logic                 w_rsp;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_out_next;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_room;
    logic [1:0]           w_count;
    logic [1:0]           w_count_next;
    logic [2:0]           w_occupancy;

    // JALR wins over JAL/branch; JAL and branch share the PC-relative formula.
    assign w_redirect   = BE_i | UJE_i | JALRE_i;
    assign w_br_target  = PC_br_i + {immed_i[DATAWIDTH-2:0], 1'b0};
    assign w_jalr_sum   = jalr_base_i + immed_i;
    assign w_target_raw = JALRE_i ? {w_jalr_sum[DATAWIDTH-1:1], 1'b0} : w_br_target;

`ifdef ATOMRVCORE_IFU_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign;
    assign w_target         = w_target_raw;
    assign w_misalign       = w_redirect & w_target_raw[1];
    assign w_halted         = (r_state == S_HALT);
    assign fetch_misalign_o = r_misalign;
`else
    assign w_target = w_target_raw & ~DATAWIDTH'(3);
    assign w_halted = 1'b0;
`endif

    // A response only counts while a fetch is in flight; redirects cancel push and pop.
    assign w_gnt_acc   = (r_state == S_REQ) && r_req && imem.imem_gnt_i;
    assign w_rsp       = imem.imem_rvalid_i && r_outstanding;
    assign w_push      = w_rsp && !r_discard && !w_redirect && !w_halted;
    assign w_pop       = !w_empty && !stall_i && !w_redirect;
    assign w_out_next  = w_gnt_acc || (r_outstanding && !imem.imem_rvalid_i);
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_outstanding};
    assign w_room      = !w_full && (w_occupancy < 3'(BUF_DEPTH));

    always_comb begin
        w_count_next = w_count;
        if (w_redirect) begin
            w_count_next = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_next = w_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_next = w_count - 2'd1;
        end
    end

    // Requests stay low while a stale fetch is still in flight, keeping one transaction max.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_req         <= 1'b0;
`ifdef ATOMRVCORE_IFU_ALIGN_CHECK_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            r_outstanding <= w_out_next;
            if (w_redirect && w_out_next) begin
                r_discard <= 1'b1;
            end else if (w_rsp) begin
                r_discard <= 1'b0;
            end
            if (w_gnt_acc) begin
                r_req_pc <= r_pc;
            end

            if (w_halted) begin
                r_req <= 1'b0;
            end else if (w_redirect) begin
                r_pc    <= w_target;
                r_state <= S_REQ;
                r_req   <= !w_out_next;
`ifdef ATOMRVCORE_IFU_ALIGN_CHECK_EN
                if (w_misalign) begin
                    r_state    <= S_HALT;
                    r_req      <= 1'b0;
                    r_misalign <= 1'b1;
                end
`endif
            end else begin
                case (r_state)
                    S_RESET: begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                    S_REQ: begin
                        if (w_gnt_acc) begin
                            r_pc    <= r_pc + DATAWIDTH'(4);
                            r_state <= S_WAIT;
                            r_req   <= 1'b0;
                        end else if (!w_room) begin
                            r_state <= S_FULL;
                            r_req   <= 1'b0;
                        end else begin
                            r_req <= !w_out_next;
                        end
                    end
                    S_WAIT: begin
                        if (w_rsp) begin
                            if (w_count_next == 2'(BUF_DEPTH)) begin
                                r_state <= S_FULL;
                                r_req   <= 1'b0;
                            end else begin
                                r_state <= S_REQ;
                                r_req   <= 1'b1;
                            end
                        end
                    end
                    S_FULL: begin
                        if (w_pop) begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_RESET;
                        r_req   <= 1'b0;
                    end
                endcase
            end
        end
    end

    atomrvcore_ifu_buf #(
        .DATAWIDTH(DATAWIDTH)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (w_push),
        .push_pc_i    (r_req_pc),
        .push_instr_i (imem.imem_rdata_i),
        .pop_i        (w_pop),
        .flush_i      (w_redirect),
        .head_pc_o    (PC_o),
        .head_instr_o (instr_o),
        .count_o      (w_count),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

    assign instr_valid_o    = !w_empty;
    assign imem.imem_req_o  = r_req;
    assign imem.imem_addr_o = r_pc;

endmodule

// File: tb/tb_atomrvcore_ifu.sv
// Directed bench for atomrvcore_ifu: reset, latency, stall/backpressure, redirects,
// stale-response discard, reset mid-fetch and (with the macro) misaligned-target halt.
module tb_atomrvcore_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        be;
    logic        uje;
    logic        jalre;
    logic [31:0] pcBr;
    logic [31:0] immed;
    logic [31:0] jalrBase;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic        validOut;
`ifdef ATOMRVCORE_IFU_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int nChecks;
    int nFails;

    atomrvcore_ifu_if #(.DATAWIDTH(32)) imemIf ();

    atomrvcore_ifu #(
        .DATAWIDTH (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem             (imemIf),
        .instr_o          (instrOut),
        .PC_o             (pcOut),
        .instr_valid_o    (validOut),
        .stall_i          (stall),
        .BE_i             (be),
        .UJE_i            (uje),
        .JALRE_i          (jalre),
        .PC_br_i          (pcBr),
        .immed_i          (immed),
        .jalr_base_i      (jalrBase)
`ifdef ATOMRVCORE_IFU_ALIGN_CHECK_EN
        ,
        .fetch_misalign_o (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic gnt, input logic rvalid,
                                 input logic [31:0] rdata, input logic stl);
        imemIf.imem_gnt_i    = gnt;
        imemIf.imem_rvalid_i = rvalid;
        imemIf.imem_rdata_i  = rdata;
        stall                = stl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        nChecks  = 0;
        nFails   = 0;
        rst      = 1'b1;
        be       = 1'b0;
        uje      = 1'b0;
        jalre    = 1'b0;
        pcBr     = '0;
        immed    = '0;
        jalrBase = '0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        tick();
        checkOutput("rst_req",   32'(imemIf.imem_req_o), 32'd0);
        checkOutput("rst_addr",  imemIf.imem_addr_o, 32'h0);
        checkOutput("rst_valid", 32'(validOut), 32'd0);
        checkOutput("rst_instr", instrOut, NOP);
        checkOutput("rst_pc",    pcOut, 32'h0);

        rst = 1'b0;
        tick();
        checkOutput("first_req",  32'(imemIf.imem_req_o), 32'd1);
        checkOutput("first_addr", imemIf.imem_addr_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        tick();
        checkOutput("wait_req", 32'(imemIf.imem_req_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0050_0093, 1'b0);

        tick();
        checkOutput("lat_valid", 32'(validOut), 32'd1);
        checkOutput("lat_pc",    pcOut, 32'h0);
        checkOutput("lat_instr", instrOut, 32'h0050_0093);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        tick();
        applyStimulus(1'b0, 1'b1, 32'h00A0_0113, 1'b1);

        tick();
        checkOutput("full_req",  32'(imemIf.imem_req_o), 32'd0);
        checkOutput("full_head", pcOut, 32'h0);
        checkOutput("full_addr", imemIf.imem_addr_o, 32'h8);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("stall_req", 32'(imemIf.imem_req_o), 32'd0);
        end

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("drain_pc4",    pcOut, 32'h4);
        checkOutput("drain_instr4", instrOut, 32'h00A0_0113);
        checkOutput("drain_req",    32'(imemIf.imem_req_o), 32'd1);
        checkOutput("drain_addr",   imemIf.imem_addr_o, 32'h8);

        tick();
        checkOutput("gap_valid", 32'(validOut), 32'd0);
        checkOutput("gap_instr", instrOut, NOP);
        applyStimulus(1'b0, 1'b1, 32'h0030_8193, 1'b0);

        tick();
        checkOutput("drain_pc8", pcOut, 32'h8);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        tick();
        applyStimulus(1'b0, 1'b1, 32'h0040_0213, 1'b0);
        tick();
        checkOutput("pc_c", pcOut, 32'hC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0050_0293, 1'b1);
        tick();
        checkOutput("pre_br_addr", imemIf.imem_addr_o, 32'h14);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("pre_br_pc",    pcOut, 32'h10);
        checkOutput("pre_br_valid", 32'(validOut), 32'd1);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        be    = 1'b1;
        pcBr  = 32'h10;
        immed = 32'h8;
        tick();
        be = 1'b0;
        checkOutput("br_flush",     32'(validOut), 32'd0);
        checkOutput("br_addr",      imemIf.imem_addr_o, 32'h20);
        checkOutput("br_stale_req", 32'(imemIf.imem_req_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        tick();
        checkOutput("br_drop_valid", 32'(validOut), 32'd0);
        checkOutput("br_req",        32'(imemIf.imem_req_o), 32'd1);
        checkOutput("br_req_addr",   imemIf.imem_addr_o, 32'h20);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0060_0313, 1'b0);
        tick();
        checkOutput("br_first_pc",    pcOut, 32'h20);
        checkOutput("br_first_instr", instrOut, 32'h0060_0313);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        jalre    = 1'b1;
        be       = 1'b1;
        jalrBase = 32'h101;
        immed    = 32'h4;
        pcBr     = 32'h10;
        tick();
        jalre = 1'b0;
        be    = 1'b0;
        checkOutput("jalr_addr",  imemIf.imem_addr_o, 32'h104);
        checkOutput("jalr_req",   32'(imemIf.imem_req_o), 32'd1);
        checkOutput("jalr_flush", 32'(validOut), 32'd0);

        uje   = 1'b1;
        pcBr  = 32'h40;
        immed = 32'h10;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        uje = 1'b0;
        checkOutput("jal_addr", imemIf.imem_addr_o, 32'h60);
        checkOutput("jal_req",  32'(imemIf.imem_req_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        checkOutput("jal_drop_valid", 32'(validOut), 32'd0);
        checkOutput("jal_req_after",  32'(imemIf.imem_req_o), 32'd1);

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("rstw_wait_req", 32'(imemIf.imem_req_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("rstw_req",  32'(imemIf.imem_req_o), 32'd0);
        checkOutput("rstw_addr", imemIf.imem_addr_o, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        checkOutput("rstw_first_req",  32'(imemIf.imem_req_o), 32'd1);
        checkOutput("rstw_first_addr", imemIf.imem_addr_o, 32'h0);
        checkOutput("rstw_valid",      32'(validOut), 32'd0);
        tick();
        checkOutput("rstw_ignored", 32'(validOut), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0070_0393, 1'b0);
        tick();
        checkOutput("rstw_pc",     pcOut, 32'h0);
        checkOutput("rstw_instr",  instrOut, 32'h0070_0393);
        checkOutput("rstw_valid2", 32'(validOut), 32'd1);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        uje   = 1'b1;
        pcBr  = 32'h20;
        immed = 32'h1;
        tick();
        uje = 1'b0;
`ifdef ATOMRVCORE_IFU_ALIGN_CHECK_EN
        checkOutput("mis_flag",  32'(misalign), 32'd1);
        checkOutput("mis_req",   32'(imemIf.imem_req_o), 32'd0);
        checkOutput("mis_valid", 32'(validOut), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("halt_req",  32'(imemIf.imem_req_o), 32'd0);
            checkOutput("halt_flag", 32'(misalign), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("mis_rst_flag", 32'(misalign), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("mis_rst_req",  32'(imemIf.imem_req_o), 32'd1);
        checkOutput("mis_rst_addr", imemIf.imem_addr_o, 32'h0);
`else
        checkOutput("align_addr",  imemIf.imem_addr_o, 32'h20);
        checkOutput("align_req",   32'(imemIf.imem_req_o), 32'd1);
        checkOutput("align_valid", 32'(validOut), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
